// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-SRC control unit: opcodes, ALU codes, opcode classes and
// the sequencer state encoding.
package cpu_pkg;

    localparam int unsigned OPW    = 5;
    localparam int unsigned ALUOPW = 5;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    // ALU operation codes share the R-type opcode values
    localparam logic [ALUOPW-1:0] ALU_ADD = 5'b00011;
    localparam logic [ALUOPW-1:0] ALU_AND = 5'b00101;
    localparam logic [ALUOPW-1:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        ClsRtype, ClsImm, ClsLdi, ClsLd, ClsSt, ClsBr, ClsJr, ClsNop, ClsHalt, ClsIll
    } op_class_t;

    localparam logic [3:0] StRst  = 4'd0;
    localparam logic [3:0] StT0   = 4'd1;
    localparam logic [3:0] StT1   = 4'd2;
    localparam logic [3:0] StT2   = 4'd3;
    localparam logic [3:0] StT3   = 4'd4;
    localparam logic [3:0] StT4   = 4'd5;
    localparam logic [3:0] StT5   = 4'd6;
    localparam logic [3:0] StT6   = 4'd7;
    localparam logic [3:0] StT7   = 4'd8;
    localparam logic [3:0] StIdle = 4'd9;
    localparam logic [3:0] StHalt = 4'd10;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: maps ir[31:27] onto the execute-sequence class used by the
// control sequencer.
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output logic [3:0]     op_class
);

    always_comb begin
        op_class = ClsIll;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: op_class = ClsRtype;
            OP_ADDI, OP_ANDI, OP_ORI:                      op_class = ClsImm;
            OP_LDI:                                        op_class = ClsLdi;
            OP_LD:                                         op_class = ClsLd;
            OP_ST:                                         op_class = ClsSt;
            OP_BR:                                         op_class = ClsBr;
            OP_JR:                                         op_class = ClsJr;
            OP_NOP:                                        op_class = ClsNop;
            OP_HALT:                                       op_class = ClsHalt;
            default:                                       op_class = ClsIll;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for the mini-SRC datapath: fetch T0-T2, per-class execute T3-T7,
// memory handshakes held until mem_rdy, stop honoured only at instruction boundaries.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       ir,
    input  logic              con_in,
    input  logic              mem_rdy,
    input  logic              stop,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              PCout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              Cout,
    output logic              PCin,
    output logic              IncPC,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              Yin,
    output logic              Zin,
    output logic              CONin,
    output logic              Read,
    output logic              Write,
    output logic [ALUOPW-1:0] alu_op,
    output logic              run,
    output logic              illegal_op
);

    logic [3:0] state_q, state_d;
    logic       stay_q;
    logic       last;
    logic [3:0] op_class;
    logic       unused_ir;

    assign unused_ir = ^ir[26:0];

    op_class_decode u_op_class_decode (
        .opcode   (ir[31:27]),
        .op_class (op_class)
    );

    always_comb begin
        state_d = state_q;
        last    = 1'b0;
        case (state_q)
            StRst:  state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (mem_rdy) state_d = StT2;
            StT2:   state_d = StT3;
            StT3: begin
                if (op_class == ClsHalt) begin
                    state_d = StHalt;
                end else if (op_class == ClsJr || op_class == ClsNop || op_class == ClsIll) begin
                    last = 1'b1;
                end else begin
                    state_d = StT4;
                end
            end
            StT4:   state_d = StT5;
            StT5: begin
                if (op_class == ClsLd || op_class == ClsSt || op_class == ClsBr) state_d = StT6;
                else last = 1'b1;
            end
            StT6: begin
                if (op_class == ClsLd) begin
                    if (mem_rdy) state_d = StT7;
                end else if (op_class == ClsSt) begin
                    state_d = StT7;
                end else begin
                    last = 1'b1;
                end
            end
            StT7:   last = (op_class == ClsLd) ? 1'b1 : mem_rdy;
            StIdle: if (!stop) state_d = StT0;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
        if (last) state_d = stop ? StIdle : StT0;
    end

    // stay_q marks a repeated cycle in the same state, so T1 updates PC only on entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRst;
            stay_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stay_q  <= (state_d == state_q);
        end
    end

    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
        PCin = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
        alu_op     = '0;
        illegal_op = 1'b0;
        run = !(state_q == StRst || state_q == StIdle || state_q == StHalt);
        case (state_q)
            StT0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            StT1: begin
                Zlowout = !stay_q; PCin = !stay_q; Read = 1'b1; MDRin = mem_rdy;
            end
            StT2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            StT3: begin
                if (op_class == ClsRtype || op_class == ClsImm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (op_class == ClsLdi || op_class == ClsLd || op_class == ClsSt) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (op_class == ClsBr) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (op_class == ClsJr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (op_class == ClsIll) begin
                    illegal_op = 1'b1;
                end
            end
            StT4: begin
                if (op_class == ClsRtype) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ir[31:27];
                end else if (op_class == ClsImm) begin
                    Cout = 1'b1; Zin = 1'b1;
                    alu_op = (ir[31:27] == OP_ADDI) ? ALU_ADD :
                             (ir[31:27] == OP_ANDI) ? ALU_AND : ALU_OR;
                end else if (op_class == ClsBr) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
                end
            end
            StT5: begin
                if (op_class == ClsLd || op_class == ClsSt) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (op_class == ClsBr) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
                end else begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            StT6: begin
                if (op_class == ClsLd) begin
                    Read = 1'b1; MDRin = mem_rdy;
                end else if (op_class == ClsSt) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else begin
                    Zlowout = con_in; PCin = con_in;
                end
            end
            StT7: begin
                if (op_class == ClsLd) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of fetch/execute vectors for add, plus
// per-instruction expected-strobe sequences generated from the opcode semantics.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ir;
    logic        con_in, mem_rdy, stop;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zlowout, MDRout, Cout;
    logic PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, CONin, Read, Write;
    logic [4:0] alu_op;
    logic run, illegal_op;

    control_sequencer dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .con_in(con_in), .mem_rdy(mem_rdy),
        .stop(stop), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .PCin(PCin),
        .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    localparam logic [26:0] NONE    = 27'd0;
    localparam logic [26:0] GRA     = 27'd1 << 0;
    localparam logic [26:0] GRB     = 27'd1 << 1;
    localparam logic [26:0] GRC     = 27'd1 << 2;
    localparam logic [26:0] RIN     = 27'd1 << 3;
    localparam logic [26:0] ROUT    = 27'd1 << 4;
    localparam logic [26:0] BAOUT   = 27'd1 << 5;
    localparam logic [26:0] PCOUT   = 27'd1 << 6;
    localparam logic [26:0] ZLOWOUT = 27'd1 << 7;
    localparam logic [26:0] MDROUT  = 27'd1 << 8;
    localparam logic [26:0] COUT    = 27'd1 << 9;
    localparam logic [26:0] PCIN    = 27'd1 << 10;
    localparam logic [26:0] INCPC   = 27'd1 << 11;
    localparam logic [26:0] IRIN    = 27'd1 << 12;
    localparam logic [26:0] MARIN   = 27'd1 << 13;
    localparam logic [26:0] MDRIN   = 27'd1 << 14;
    localparam logic [26:0] YIN     = 27'd1 << 15;
    localparam logic [26:0] ZIN     = 27'd1 << 16;
    localparam logic [26:0] CONIN   = 27'd1 << 17;
    localparam logic [26:0] READ    = 27'd1 << 18;
    localparam logic [26:0] WRITE   = 27'd1 << 19;
    localparam logic [26:0] RUN     = 27'd1 << 25;
    localparam logic [26:0] ILL     = 27'd1 << 26;

    logic [26:0] act;
    assign act = {illegal_op, run, alu_op, Write, Read, CONin, Zin, Yin, MDRin, MARin, IRin,
                  IncPC, PCin, Cout, MDRout, Zlowout, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

    typedef struct {
        logic [31:0] ir;
        logic        mem_rdy;
        logic        con_in;
        logic        stop;
        logic [26:0] exp;
    } step_t;

    step_t       q[$];
    step_t       add_tab[8];
    logic [31:0] cur_ir;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [26:0] aop(input logic [4:0] a);
        return {2'b00, a, 20'd0};
    endfunction

    function automatic logic rb();
        logic [31:0] r;
        r = $urandom();
        return r[0];
    endfunction

    task automatic check(input string name, input logic [26:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: outputs got %h want %h", name, act, want);
        end
    endtask

    task automatic push(input logic rdy, input logic con, input logic stp, input logic [26:0] e);
        step_t s;
        s.ir = cur_ir; s.mem_rdy = rdy; s.con_in = con; s.stop = stp; s.exp = e;
        q.push_back(s);
    endtask

    // Last step of an instruction: stop here decides between IDLE and the next fetch
    task automatic fin(input logic rdy, input logic con, input logic stop_end, input int idle_n,
                       input logic [26:0] e);
        push(rdy, con, stop_end, e | RUN);
        if (stop_end) begin
            repeat (idle_n) push(rb(), con, 1'b1, NONE);
            push(rb(), con, 1'b0, NONE);
        end
    endtask

    task automatic gen_instr(input logic [4:0] op, input logic con, input logic stop_end,
                             input int d1, input int d6, input int d7, input int idle_n);
        logic [31:0] r;
        r = $urandom();
        cur_ir = {op, r[26:0]};
        push(rb(), con, rb(), PCOUT | MARIN | INCPC | ZIN | RUN);
        for (int i = 0; i <= d1; i++)
            push(i == d1, con, rb(), READ | RUN | ((i == 0) ? (ZLOWOUT | PCIN) : NONE) |
                 ((i == d1) ? MDRIN : NONE));
        push(rb(), con, rb(), MDROUT | IRIN | RUN);
        if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}) begin
            push(rb(), con, rb(), GRB | ROUT | YIN | RUN);
            push(rb(), con, rb(), GRC | ROUT | ZIN | aop(op) | RUN);
            fin(rb(), con, stop_end, idle_n, ZLOWOUT | GRA | RIN);
        end else if (op inside {5'd12, 5'd13, 5'd14}) begin
            push(rb(), con, rb(), GRB | ROUT | YIN | RUN);
            push(rb(), con, rb(), COUT | ZIN | RUN |
                 aop(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd5 : 5'd6)));
            fin(rb(), con, stop_end, idle_n, ZLOWOUT | GRA | RIN);
        end else if (op inside {5'd0, 5'd1, 5'd2}) begin
            push(rb(), con, rb(), GRB | BAOUT | YIN | RUN);
            push(rb(), con, rb(), COUT | ZIN | aop(5'd3) | RUN);
            if (op == 5'd1) begin
                fin(rb(), con, stop_end, idle_n, ZLOWOUT | GRA | RIN);
            end else begin
                push(rb(), con, rb(), ZLOWOUT | MARIN | RUN);
                if (op == 5'd0) begin
                    for (int i = 0; i <= d6; i++)
                        push(i == d6, con, rb(), READ | RUN | ((i == d6) ? MDRIN : NONE));
                    fin(rb(), con, stop_end, idle_n, MDROUT | GRA | RIN);
                end else begin
                    push(rb(), con, rb(), GRA | ROUT | MDRIN | RUN);
                    for (int i = 0; i < d7; i++) push(1'b0, con, rb(), WRITE | RUN);
                    fin(1'b1, con, stop_end, idle_n, WRITE);
                end
            end
        end else if (op == 5'd18) begin
            push(rb(), con, rb(), GRA | ROUT | CONIN | RUN);
            push(rb(), con, rb(), PCOUT | YIN | RUN);
            push(rb(), con, rb(), COUT | ZIN | aop(5'd3) | RUN);
            fin(rb(), con, stop_end, idle_n, con ? (ZLOWOUT | PCIN) : NONE);
        end else if (op == 5'd19) begin
            fin(rb(), con, stop_end, idle_n, GRA | ROUT | PCIN);
        end else if (op == 5'd25) begin
            fin(rb(), con, stop_end, idle_n, NONE);
        end else if (op == 5'd26) begin
            push(rb(), con, rb(), RUN);
            repeat (20) push(rb(), rb(), rb(), NONE);
        end else begin
            fin(rb(), con, stop_end, idle_n, ILL);
        end
    endtask

    task automatic run_queue(input string name, input int limit);
        int n;
        n = q.size();
        if (limit >= 0 && limit < n) n = limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ir = q[i].ir; mem_rdy = q[i].mem_rdy; con_in = q[i].con_in; stop = q[i].stop;
            #1;
            check($sformatf("%s[%0d]", name, i), q[i].exp);
        end
        q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_low", NONE);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cur_ir = $urandom();
        push(rb(), rb(), rb(), NONE);
    endtask

    initial begin
        reset_n = 1'b0; ir = '0; con_in = 1'b0; mem_rdy = 1'b0; stop = 1'b0;

        add_tab[0] = '{32'h18918000, 1'b1, 1'b0, 1'b0, NONE};
        add_tab[1] = '{32'h18918000, 1'b1, 1'b0, 1'b0, PCOUT | MARIN | INCPC | ZIN | RUN};
        add_tab[2] = '{32'h18918000, 1'b1, 1'b0, 1'b0, ZLOWOUT | PCIN | READ | MDRIN | RUN};
        add_tab[3] = '{32'h18918000, 1'b1, 1'b0, 1'b0, MDROUT | IRIN | RUN};
        add_tab[4] = '{32'h18918000, 1'b1, 1'b0, 1'b0, GRB | ROUT | YIN | RUN};
        add_tab[5] = '{32'h18918000, 1'b1, 1'b0, 1'b0, GRC | ROUT | ZIN | aop(5'b00011) | RUN};
        add_tab[6] = '{32'h18918000, 1'b1, 1'b0, 1'b0, ZLOWOUT | GRA | RIN | RUN};
        add_tab[7] = '{32'h18918000, 1'b1, 1'b0, 1'b0, PCOUT | MARIN | INCPC | ZIN | RUN};

        // add vectors from the table (do_reset queues its own RST step; replace with table's)
        do_reset();
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(add_tab[i]);
        run_queue("add_tab", -1);

        // ld with memory delayed 3 cycles in both T1 and T6
        do_reset();
        gen_instr(5'b00000, 1'b0, 1'b0, 3, 3, 0, 0);
        run_queue("ld_wait", -1);

        // br not taken, then taken
        gen_instr(5'b10010, 1'b0, 1'b0, 0, 0, 0, 0);
        gen_instr(5'b10010, 1'b1, 1'b0, 1, 0, 0, 0);
        run_queue("br", -1);

        // stop at end of add: IDLE for a while, then resume with a nop
        gen_instr(5'b00011, 1'b0, 1'b1, 0, 0, 0, 3);
        gen_instr(5'b11001, 1'b0, 1'b0, 0, 0, 0, 0);
        run_queue("stop_idle", -1);

        // unknown opcode then st with a stretched write
        gen_instr(5'b11111, 1'b0, 1'b0, 0, 0, 0, 0);
        gen_instr(5'b00010, 1'b0, 1'b0, 0, 0, 2, 0);
        run_queue("ill_st", -1);

        // reset asserted while ld waits in T6 with Read high
        gen_instr(5'b00000, 1'b0, 1'b0, 0, 5, 0, 0);
        run_queue("ld_pre_reset", 8);
        #2 reset_n = 1'b0;
        #1 check("async_reset_mid_t6", NONE);
        do_reset();
        run_queue("post_reset", -1);

        // randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            logic [31:0] r;
            logic [4:0]  op;
            r  = $urandom();
            op = r[4:0];
            if (op == 5'b11010) op = 5'b11001;
            gen_instr(op, rb(), (r[9:8] == 2'b00), int'(r[11:10]), int'(r[13:12]),
                      int'(r[15:14]), int'(r[17:16]));
            run_queue($sformatf("rand%0d_op%0d", k, op), -1);
        end

        // halt is absorbing until reset
        gen_instr(5'b11010, 1'b0, 1'b0, 0, 0, 0, 0);
        run_queue("halt", -1);
        do_reset();
        gen_instr(5'b11001, 1'b0, 1'b0, 0, 0, 0, 0);
        run_queue("after_halt", -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
